// File: rtl/nios_cpu_qsys_cpu_cpu_mul_combine_pkg.sv
`default_nettype none
// ============================================================================
// Module  : nios_cpu_qsys_cpu_cpu_mul_combine_pkg
// Brief   : Shared widths, stage record and combine helper for the MUL combiner
// Revision: 1.0 - initial release
// ============================================================================
package nios_cpu_qsys_cpu_cpu_mul_combine_pkg;

  localparam int MUL_W  = 32;
  localparam int HALF_W = MUL_W / 2;

  typedef struct packed {
    logic              valid;
    logic [MUL_W-1:0]  p1;
    logic [HALF_W-1:0] mid;
  } stage_t;

  // Only the low half of the cross terms can land inside the 32-bit result.
  function automatic logic [MUL_W-1:0] mul_combine(
    input logic [MUL_W-1:0]  p1,
    input logic [HALF_W-1:0] mid
  );
    return p1 + {mid, {HALF_W{1'b0}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/nios_cpu_qsys_cpu_cpu_mul_combine_if.sv
`default_nettype none
// ============================================================================
// Module  : nios_cpu_qsys_cpu_cpu_mul_combine_if
// Brief   : M-stage partial products in, W-stage multiply result out
// Revision: 1.0 - initial release
// ============================================================================
interface nios_cpu_qsys_cpu_cpu_mul_combine_if;
  import nios_cpu_qsys_cpu_cpu_mul_combine_pkg::*;

  logic [MUL_W-1:0] M_mul_cell_p1;
  logic [MUL_W-1:0] M_mul_cell_p2;
  logic [MUL_W-1:0] M_mul_cell_p3;
  logic             M_en;
  logic             M_mul_valid;
  logic             M_flush;
  logic [MUL_W-1:0] W_mul_result;
  logic             W_mul_valid;

  modport master (
    output M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3,
    output M_en, M_mul_valid, M_flush,
    input  W_mul_result, W_mul_valid
  );

  modport slave (
    input  M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3,
    input  M_en, M_mul_valid, M_flush,
    output W_mul_result, W_mul_valid
  );

endinterface
`default_nettype wire

// File: rtl/nios_cpu_qsys_cpu_cpu_mul_combine_stage.sv
`default_nettype none
// ============================================================================
// Module  : nios_cpu_qsys_cpu_cpu_mul_combine_stage
// Brief   : One enable/flush/async-reset pipeline register (valid + data)
// Revision: 1.0 - initial release
// ============================================================================
module nios_cpu_qsys_cpu_cpu_mul_combine_stage #(
  parameter int DATA_W = 32
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              en_i,
  input  wire logic              flush_i,
  input  wire logic              valid_i,
  input  wire logic [DATA_W-1:0] data_i,
  output logic                   valid_o,
  output logic [DATA_W-1:0]      data_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  // Flush kills the valid bit even while stalled; data only follows the enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (flush_i) begin
        valid_q <= 1'b0;
      end else if (en_i) begin
        valid_q <= valid_i;
      end
      if (en_i) begin
        data_q <= data_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/nios_cpu_qsys_cpu_cpu_mul_combine.sv
`default_nettype none
// ============================================================================
// Module  : nios_cpu_qsys_cpu_cpu_mul_combine
// Brief   : Combines multiplier-cell partials into the low 32 bits of src1*src2.
//           Define NIOS_MUL_COMBINE_OUT_REG_EN to add a registered output stage.
// Revision: 1.0 - initial release
// ============================================================================
module nios_cpu_qsys_cpu_cpu_mul_combine #(
  parameter int MUL_W = 32
) (
  input  wire logic                         clk,
  input  wire logic                         reset,
  nios_cpu_qsys_cpu_cpu_mul_combine_if.slave mul_if
);
  import nios_cpu_qsys_cpu_cpu_mul_combine_pkg::*;

  localparam int A_DATA_W = $bits(stage_t) - 1;

  stage_t              stage_a_d;
  stage_t              stage_a_q;
  logic                a_valid_q;
  logic [A_DATA_W-1:0] a_data_q;
  logic [MUL_W-1:0]    result_a;
  logic                last_valid;
  logic [MUL_W-1:0]    last_result;
  logic                w_valid;

  // Flush wins over a same-cycle valid.
  always_comb begin
    stage_a_d       = '0;
    stage_a_d.valid = mul_if.M_mul_valid & ~mul_if.M_flush;
    stage_a_d.p1    = mul_if.M_mul_cell_p1;
    stage_a_d.mid   = mul_if.M_mul_cell_p2[HALF_W-1:0] + mul_if.M_mul_cell_p3[HALF_W-1:0];
  end

  nios_cpu_qsys_cpu_cpu_mul_combine_stage #(
    .DATA_W (A_DATA_W)
  ) u_stage_a (
    .clk     (clk),
    .reset   (reset),
    .en_i    (mul_if.M_en),
    .flush_i (mul_if.M_flush),
    .valid_i (stage_a_d.valid),
    .data_i  ({stage_a_d.p1, stage_a_d.mid}),
    .valid_o (a_valid_q),
    .data_o  (a_data_q)
  );

  assign stage_a_q = {a_valid_q, a_data_q};
  assign result_a  = mul_combine(stage_a_q.p1, stage_a_q.mid);

`ifdef NIOS_MUL_COMBINE_OUT_REG_EN
  nios_cpu_qsys_cpu_cpu_mul_combine_stage #(
    .DATA_W (MUL_W)
  ) u_stage_b (
    .clk     (clk),
    .reset   (reset),
    .en_i    (mul_if.M_en),
    .flush_i (mul_if.M_flush),
    .valid_i (stage_a_q.valid),
    .data_i  (result_a),
    .valid_o (last_valid),
    .data_o  (last_result)
  );
`else
  assign last_valid  = stage_a_q.valid;
  assign last_result = result_a;
`endif

  // A result is only consumed by W on an advancing cycle.
  assign w_valid             = last_valid & mul_if.M_en;
  assign mul_if.W_mul_valid  = w_valid;
  assign mul_if.W_mul_result = w_valid ? last_result : '0;

endmodule
`default_nettype wire

// File: doc/nios_cpu_qsys_cpu_cpu_mul_combine.md
NIOS_CPU_QSYS_CPU_CPU_MUL_COMBINE -- requirements
Module: nios_cpu_qsys_cpu_cpu_mul_combine

Interface
REQ-001 SHALL have parameter MUL_W, default 32: width of each partial product and of the result.
REQ-002 SHALL have port clk, input, 1: single clock for all registers.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port M_mul_cell_p1, input, 32: lo(src1) x lo(src2) from the multiplier cell.
REQ-005 SHALL have port M_mul_cell_p2, input, 32: lo(src1) x hi(src2).
REQ-006 SHALL have port M_mul_cell_p3, input, 32: hi(src1) x lo(src2).
REQ-007 SHALL have port M_en, input, 1: pipeline advance; low = stall.
REQ-008 SHALL have port M_mul_valid, input, 1: the M-stage instruction is a MUL and the partials are valid.
REQ-009 SHALL have port M_flush, input, 1: kill all in-flight multiply results.
REQ-010 SHALL have port W_mul_result, output, 32: low 32 bits of src1 x src2.
REQ-011 SHALL have port W_mul_valid, output, 1: W_mul_result is valid this cycle.

Function
REQ-012 SHALL compute mid = p2[15:0] + p3[15:0], truncated to 16 bits; upper partial bits are ignored.
REQ-013 SHALL compute result = p1 + {mid, 16'h0000} modulo 2^32, with carry-out discarded.
REQ-014 Stage A SHALL register p1, mid and valid_a = M_mul_valid & ~M_flush on each clk edge where M_en = 1.
REQ-015 Without the macro, W_mul_result SHALL be combinational from the stage A registers; latency is 1 enabled cycle.
REQ-016 When M_en = 0, all pipeline registers SHALL hold, and outputs SHALL stay stable.
REQ-017 M_flush = 1 SHALL clear every valid bit on the next clk edge, regardless of M_en; data registers need not clear.
REQ-018 When flush and a new valid arrive in the same cycle, flush SHALL win and no valid is produced.
REQ-019 W_mul_valid SHALL be the last-stage valid bit ANDed with M_en; W_mul_result SHALL be 0 whenever W_mul_valid = 0.
REQ-020 Back-to-back valid multiplies SHALL each produce exactly one W_mul_valid pulse, in order, with no bubbles inserted.

Reset
REQ-021 On reset assertion, all valid bits and data registers SHALL clear to 0 immediately (asynchronous).
REQ-022 While reset is asserted, W_mul_valid = 0 and W_mul_result = 0.
REQ-023 A multiply in flight when reset asserts SHALL be discarded and never reported after release.
REQ-024 The first sampling edge after deassertion SHALL behave as a normal edge.

Configuration
REQ-025 Macro NIOS_MUL_COMBINE_OUT_REG_EN, when defined, SHALL add stage B.
- Stage B registers result and valid_a under the same M_en, flush and reset rules.
- Latency becomes 2 enabled cycles.
- W_mul_result is driven from a flop.
REQ-026 When the macro is undefined, there SHALL be no stage B and latency is 1 (REQ-015).

Structure
REQ-027 A shared package SHALL hold MUL_W, HALF_W = MUL_W/2, and a stage struct typedef {valid, p1, mid}.
REQ-028 One sub-module, nios_cpu_qsys_cpu_cpu_mul_combine_stage, SHALL implement one enable/flush/reset pipeline register.
- Instantiated once per stage.
- Used a second time when NIOS_MUL_COMBINE_OUT_REG_EN is defined.

Verification
REQ-029 Basic multiply: p1=8, p2=6, p3=4 (0x00010002 x 0x00030004), valid, M_en=1 -> W_mul_result = 0x000A0008 with W_mul_valid after 1 cycle (2 with macro).
REQ-030 Wrap-around: p1=p2=p3=0xFFFE0001 (0xFFFFFFFF squared) -> W_mul_result = 0x00000001.
REQ-031 Stall: hold M_en=0 for 3 cycles mid-flight -> output frozen, no W_mul_valid; the result appears on the cycle after M_en returns to 1.
REQ-032 Flush race: valid and M_flush asserted together -> no W_mul_valid; the following valid multiply still completes correctly.
REQ-033 Reset: assert reset with 2 multiplies in flight -> outputs are 0 at once, and no W_mul_valid after release.
REQ-034 Throughput: 4 consecutive multiplies with p1 = 1, 2, 3, 4 and p2 = p3 = 0 -> results 1, 2, 3, 4 on 4 consecutive cycles.
